// File: rtl/fir_decimate.sv
// Decimating real-valued FIR low-pass stage: FWFT FIFO in, one Q10 MAC per cycle,
// one filtered sample written downstream per DECIMATION samples read.
//
// state | meaning
// ------+-----------------------------------------------------------------
// READ  | pop samples into the shift buffer until DECIMATION have arrived
// RUN   | one tap per cycle: sum += (buf[i] * COEFFS[i]) >>> 10
// WRITE | push sum downstream once the output FIFO has room
module fir_decimate #(
    parameter int TAP_NUMBER = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DECIMATION = 8,
    parameter logic [0:TAP_NUMBER-1][DATA_WIDTH-1:0] COEFFS = {TAP_NUMBER{DATA_WIDTH'(32)}}
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_dout,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    output logic [DATA_WIDTH-1:0] out_din,
    output logic                  out_wr_en,
    input  logic                  out_full
);

    localparam int TAP_IDX_W = (TAP_NUMBER > 1) ? $clog2(TAP_NUMBER) : 1;

    typedef enum logic [1:0] {READ, RUN, WRITE} state_t;

    state_t                  state;
    logic                    reset_hold;
    logic [5:0]              read_cnt;
    logic [5:0]              tap_cnt;
    logic [DATA_WIDTH-1:0]   sum;
    logic [DATA_WIDTH-1:0]   sample_buf [TAP_NUMBER];

    logic [TAP_IDX_W-1:0]    tap_idx;
    logic [DATA_WIDTH-1:0]   tap_sample;
    logic [DATA_WIDTH-1:0]   tap_coeff;
    logic signed [2*DATA_WIDTH-1:0] sample_ext;
    logic signed [2*DATA_WIDTH-1:0] coeff_ext;
    logic signed [2*DATA_WIDTH-1:0] product;
    logic signed [2*DATA_WIDTH-1:0] product_shifted;
    logic [DATA_WIDTH-1:0]   mul_result;

    assign tap_idx    = tap_cnt[TAP_IDX_W-1:0];
    assign tap_sample = sample_buf[tap_idx];
    assign tap_coeff  = COEFFS[tap_idx];

    // Sign-extend to full product width so the shift sees every product bit.
    always_comb begin
        sample_ext      = {{DATA_WIDTH{tap_sample[DATA_WIDTH-1]}}, tap_sample};
        coeff_ext       = {{DATA_WIDTH{tap_coeff[DATA_WIDTH-1]}}, tap_coeff};
        product         = sample_ext * coeff_ext;
        product_shifted = product >>> 10;
        mul_result      = product_shifted[DATA_WIDTH-1:0];
    end

    // FIFO strobes stay quiet during reset and for one cycle after it.
    always_comb begin
        in_rd_en  = 1'b0;
        out_wr_en = 1'b0;
        out_din   = '0;
        if (!reset && !reset_hold) begin
            if (state == READ && !in_empty) begin
                in_rd_en = 1'b1;
            end
            if (state == WRITE && !out_full) begin
                out_wr_en = 1'b1;
                out_din   = sum;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= READ;
            reset_hold <= 1'b1;
            read_cnt   <= '0;
            tap_cnt    <= '0;
            sum        <= '0;
            sample_buf <= '{default: '0};
        end else begin
            reset_hold <= 1'b0;
            case (state)
                READ: begin
                    if (in_rd_en) begin
                        sample_buf[0] <= in_dout;
                        for (int i = TAP_NUMBER - 1; i > 0; i--) begin
                            sample_buf[i] <= sample_buf[i-1];
                        end
                        if (read_cnt == 6'(DECIMATION - 1)) begin
                            read_cnt <= '0;
                            sum      <= '0;
                            tap_cnt  <= '0;
                            state    <= RUN;
                        end else begin
                            read_cnt <= read_cnt + 6'd1;
                        end
                    end
                end
                RUN: begin
                    sum <= sum + mul_result;
                    if (tap_cnt == 6'(TAP_NUMBER - 1)) begin
                        tap_cnt <= '0;
                        state   <= WRITE;
                    end else begin
                        tap_cnt <= tap_cnt + 6'd1;
                    end
                end
                WRITE: begin
                    if (out_wr_en) begin
                        state <= READ;
                    end
                end
                default: state <= READ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_decimate.sv
// Self-checking bench for fir_decimate: default instance plus two TAP=4/D=1 instances,
// compared against a queue-based Q10 FIR reference model.
module tb_fir_decimate;
    localparam int W = 32;
    localparam logic [0:3][W-1:0] B_COEFFS = {32'd100, 32'd200, 32'd300, 32'd400};

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [W-1:0] a_in_dout, a_out_din;
    logic         a_in_empty, a_in_rd_en, a_out_wr_en, a_out_full;
    logic [W-1:0] bc_in_dout, b_out_din, c_out_din;
    logic         bc_in_empty, bc_out_full;
    logic         b_in_rd_en, b_out_wr_en, c_in_rd_en, c_out_wr_en;

    fir_decimate u_a (
        .clock(clock), .reset(reset),
        .in_dout(a_in_dout), .in_empty(a_in_empty), .in_rd_en(a_in_rd_en),
        .out_din(a_out_din), .out_wr_en(a_out_wr_en), .out_full(a_out_full)
    );

    fir_decimate #(.TAP_NUMBER(4), .DATA_WIDTH(W), .DECIMATION(1), .COEFFS(B_COEFFS)) u_b (
        .clock(clock), .reset(reset),
        .in_dout(bc_in_dout), .in_empty(bc_in_empty), .in_rd_en(b_in_rd_en),
        .out_din(b_out_din), .out_wr_en(b_out_wr_en), .out_full(bc_out_full)
    );

    fir_decimate #(.TAP_NUMBER(4), .DATA_WIDTH(W), .DECIMATION(1)) u_c (
        .clock(clock), .reset(reset),
        .in_dout(bc_in_dout), .in_empty(bc_in_empty), .in_rd_en(c_in_rd_en),
        .out_din(c_out_din), .out_wr_en(c_out_wr_en), .out_full(bc_out_full)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [W-1:0] a_src[$], bc_src[$];
    logic [W-1:0] a_got[$], b_got[$], c_got[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] a_coef[$], b_coef[$], c_coef[$];
    int a_push_cyc[$], a_dth_q[$], a_lat_q[$];
    int a_pops = 0, a_full_cnt = 0;
    bit a_gap_en = 0, a_rand_full = 0, a_stall_arm = 0, a_forced = 0;
    bit bc_gap_en = 0, bc_rand_full = 0;
    bit rst_last = 1, rst_win;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     tag, $signed(got), got, $signed(exp), exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] mul_q10(input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return W'(p >>> 10);
    endfunction

    // Reference: sliding history newest-first, one output per dec samples.
    task automatic build_expected(input logic [W-1:0] samples[$], input int dec,
                                  input logic [W-1:0] c[$]);
        logic [W-1:0] hist[$];
        logic [W-1:0] acc;
        exp_q.delete();
        for (int i = 0; i < c.size(); i++) hist.push_back('0);
        for (int n = 0; n < samples.size(); n++) begin
            hist.push_front(samples[n]);
            void'(hist.pop_back());
            if ((n + 1) % dec == 0) begin
                acc = '0;
                for (int k = 0; k < c.size(); k++) acc = acc + mul_q10(hist[k], c[k]);
                exp_q.push_back(acc);
            end
        end
    endtask

    task automatic compare_q(input string tag, input logic [W-1:0] got[$], input logic [W-1:0] exp[$]);
        check({tag, "_count"}, W'(got.size()), W'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) check(tag, got[i], exp[i]);
    endtask

    task automatic do_reset(input bit clear_src);
        @(negedge clock);
        reset = 1'b1;
        a_got.delete(); a_push_cyc.delete(); a_dth_q.delete(); a_lat_q.delete();
        b_got.delete(); c_got.delete();
        a_pops = 0; a_full_cnt = 0; a_stall_arm = 0;
        if (clear_src) begin
            a_src.delete();
            bc_src.delete();
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_a(input int n, input int budget);
        int k = 0;
        while (a_got.size() < n && k < budget) begin
            @(negedge clock);
            k++;
        end
        check("a_outputs_within_budget", W'(a_got.size()), W'(n));
    endtask

    task automatic wait_bc(input int n, input int budget);
        int k = 0;
        while ((b_got.size() < n || c_got.size() < n) && k < budget) begin
            @(negedge clock);
            k++;
        end
        check("b_outputs_within_budget", W'(b_got.size()), W'(n));
        check("c_outputs_within_budget", W'(c_got.size()), W'(n));
    endtask

    // Upstream/downstream FIFO models and per-cycle protocol checks.
    initial begin
        a_in_empty = 1'b1; a_in_dout = '0; a_out_full = 1'b0;
        bc_in_empty = 1'b1; bc_in_dout = '0; bc_out_full = 1'b0;
        forever begin
            @(negedge clock);
            a_forced   = (a_full_cnt > 0);
            if (a_full_cnt > 0) a_full_cnt--;
            a_out_full = a_forced || (a_rand_full && $urandom_range(0, 3) == 0);
            a_in_empty = (a_src.size() == 0) || (a_gap_en && $urandom_range(0, 1) == 1);
            a_in_dout  = (a_src.size() != 0) ? a_src[0] : '0;
            bc_out_full = bc_rand_full && ($urandom_range(0, 2) == 0);
            bc_in_empty = (bc_src.size() == 0) || (bc_gap_en && $urandom_range(0, 1) == 1);
            bc_in_dout  = (bc_src.size() != 0) ? bc_src[0] : '0;
            #1;
            cyc++;
            rst_win = reset || rst_last;
            rst_last = reset;
            if (rst_win) begin
                check("a_rd_in_reset", W'(a_in_rd_en), '0);
                check("a_wr_in_reset", W'(a_out_wr_en), '0);
                check("b_rd_in_reset", W'(b_in_rd_en), '0);
                check("b_wr_in_reset", W'(b_out_wr_en), '0);
            end
            if (!a_out_wr_en) check("a_din_idle_zero", a_out_din, '0);
            if (a_forced) begin
                check("a_wr_while_held_full", W'(a_out_wr_en), '0);
                check("a_rd_while_held_full", W'(a_in_rd_en), '0);
            end
            if (a_in_rd_en) begin
                check("a_rd_while_empty", W'(a_in_empty), '0);
                if (a_src.size() != 0) void'(a_src.pop_front());
                a_pops++;
                if (a_pops % 8 == 0) begin
                    a_dth_q.push_back(cyc);
                    if (a_stall_arm) begin
                        a_stall_arm = 0;
                        a_full_cnt  = 52;
                        a_lat_q.push_back(53);
                    end else begin
                        a_lat_q.push_back(a_rand_full ? 0 : 33);
                    end
                end
            end
            if (a_out_wr_en) begin
                check("a_wr_while_full", W'(a_out_full), '0);
                a_got.push_back(a_out_din);
                a_push_cyc.push_back(cyc);
                check("a_push_has_input_block", W'(a_dth_q.size() > 0), W'(1));
                if (a_dth_q.size() > 0) begin
                    int d, l;
                    d = a_dth_q.pop_front();
                    l = a_lat_q.pop_front();
                    if (l != 0) check("a_write_latency", W'(cyc - d), W'(l));
                end
            end
            if (b_in_rd_en) begin
                check("b_rd_while_empty", W'(bc_in_empty), '0);
                if (bc_src.size() != 0) void'(bc_src.pop_front());
            end
            if (c_in_rd_en) check("c_rd_while_empty", W'(bc_in_empty), '0);
            if (b_out_wr_en) begin
                check("b_wr_while_full", W'(bc_out_full), '0);
                b_got.push_back(b_out_din);
            end else begin
                check("b_din_idle_zero", b_out_din, '0);
            end
            if (c_out_wr_en) begin
                check("c_wr_while_full", W'(bc_out_full), '0);
                c_got.push_back(c_out_din);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] log_q[$];
        logic [W-1:0] ramp[$];
        int k;
        for (int i = 0; i < 32; i++) a_coef.push_back(W'(32));
        b_coef = '{W'(100), W'(200), W'(300), W'(400)};
        c_coef = '{W'(32), W'(32), W'(32), W'(32)};
        ramp   = '{W'(256), W'(512), W'(768), W'(1024)};

        // Defaults, constant 1024: ramp, then steady 1024, 41-cycle cadence.
        for (int i = 0; i < 32; i++) a_src.push_back(W'(1024));
        do_reset(0);
        wait_a(4, 400);
        compare_q("a_const_ramp", a_got, ramp);
        for (int i = 1; i < a_push_cyc.size(); i++)
            check("a_output_period", W'(a_push_cyc[i] - a_push_cyc[i-1]), W'(41));
        check("a_pops_after_4_outputs", W'(a_pops), W'(32));

        // Output FIFO held full for 20 cycles of WRITE; one push of the retained sum.
        a_stall_arm = 1;
        for (int i = 0; i < 16; i++) a_src.push_back(W'(1024));
        wait_a(6, 400);
        if (a_got.size() >= 6) begin
            check("a_stall_value", a_got[4], W'(1024));
            check("a_after_stall_value", a_got[5], W'(1024));
        end

        // Random upstream gaps: same sequence.
        do_reset(1);
        a_gap_en = 1;
        for (int i = 0; i < 32; i++) a_src.push_back(W'(1024));
        wait_a(4, 2000);
        compare_q("a_gapped_ramp", a_got, ramp);
        a_gap_en = 0;

        // Reset in RUN of the 3rd output: discarded, then a fresh ramp.
        do_reset(1);
        for (int i = 0; i < 56; i++) a_src.push_back(W'(1024));
        k = 0;
        while (a_pops < 24 && k < 400) begin
            @(negedge clock);
            k++;
        end
        check("a_pops_before_midrun_reset", W'(a_pops), W'(24));
        repeat (10) @(negedge clock);
        check("a_outputs_before_midrun_reset", W'(a_got.size()), W'(2));
        do_reset(0);
        wait_a(4, 400);
        compare_q("a_after_midrun_reset", a_got, ramp);

        // Random data, gaps and downstream back-pressure against the model.
        do_reset(1);
        a_gap_en = 1; a_rand_full = 1;
        log_q.delete();
        for (int i = 0; i < 40; i++) begin
            int v;
            v = int'($urandom_range(0, 1048575)) - 524288;
            log_q.push_back(W'(v));
            a_src.push_back(W'(v));
        end
        wait_a(5, 3000);
        build_expected(log_q, 8, a_coef);
        compare_q("a_random", a_got, exp_q);
        a_gap_en = 0; a_rand_full = 0;

        // TAP=4, D=1: impulse response.
        do_reset(1);
        bc_src = '{W'(1024), W'(0), W'(0), W'(0), W'(0)};
        wait_bc(5, 200);
        exp_q = '{W'(100), W'(200), W'(300), W'(400), W'(0)};
        compare_q("b_impulse", b_got, exp_q);
        exp_q = '{W'(32), W'(32), W'(32), W'(32), W'(0)};
        compare_q("c_impulse", c_got, exp_q);

        // Stream of -1: floor rounding of the Q10 shift.
        do_reset(1);
        for (int i = 0; i < 5; i++) bc_src.push_back(W'(-1));
        wait_bc(5, 200);
        exp_q = '{W'(-1), W'(-2), W'(-3), W'(-4), W'(-4)};
        compare_q("c_neg_floor", c_got, exp_q);
        compare_q("b_neg_floor", b_got, exp_q);

        // Full-range random data (wrapping accumulation), gaps and back-pressure.
        do_reset(1);
        bc_gap_en = 1; bc_rand_full = 1;
        log_q.delete();
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] v;
            v = (i % 2 == 0) ? W'($urandom()) : W'(int'($urandom_range(0, 65535)) - 32768);
            log_q.push_back(v);
            bc_src.push_back(v);
        end
        wait_bc(40, 2000);
        build_expected(log_q, 1, b_coef);
        compare_q("b_random", b_got, exp_q);
        build_expected(log_q, 1, c_coef);
        compare_q("c_random", c_got, exp_q);
        bc_gap_en = 0; bc_rand_full = 0;

        repeat (5) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
